// File: rtl/su_cmd_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | su_cmd_decoder                                                           |
// | Smart-UART host command parser: word read/write onto the on-chip bus,    |
// | read responses back to UART TX, other bytes forwarded to the gateway.    |
// | Optional macro SU_CMD_TIMEOUT_EN adds an inter-byte timeout.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

`ifndef SU_CMD_WR_WORD
`define SU_CMD_WR_WORD 8'hA1
`endif
`ifndef SU_CMD_RD_WORD
`define SU_CMD_RD_WORD 8'hA2
`endif
`ifndef SU_CMD_RSP
`define SU_CMD_RSP 8'hA3
`endif

module su_cmd_decoder #(
  parameter logic [7:0]  CMD_WR      = `SU_CMD_WR_WORD,
  parameter logic [7:0]  CMD_RD      = `SU_CMD_RD_WORD,
  parameter logic [7:0]  CMD_RSP     = `SU_CMD_RSP,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  gw_byte,
  output logic        gw_valid,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        busy,
  output logic        err_overflow
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_DATA     = 3'd2,
    ST_BUS      = 3'd3,
    ST_RSP_HDR  = 3'd4,
    ST_RSP_DATA = 3'd5
  } state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic        wr_q;
  logic        bus_req_q;
  logic        tx_valid_q;
  logic        gw_valid_q;
  logic        err_q;
  logic [7:0]  tx_byte_q;
  logic [7:0]  gw_byte_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        w_tx_acc;
  logic        w_drop;

  assign w_tx_acc = tx_valid_q & tx_ready;
  // Bytes arriving while a transaction or response is in flight cannot be buffered.
  assign w_drop   = rx_valid & ((state_q == ST_BUS) || (state_q == ST_RSP_HDR) ||
                                (state_q == ST_RSP_DATA));

`ifdef SU_CMD_TIMEOUT_EN
  logic [31:0] tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      wr_q       <= 1'b0;
      bus_req_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      gw_valid_q <= 1'b0;
      err_q      <= 1'b0;
      tx_byte_q  <= 8'h00;
      gw_byte_q  <= 8'h00;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
`ifdef SU_CMD_TIMEOUT_EN
      tmo_q      <= 32'h0;
`endif
    end else begin
      gw_valid_q <= 1'b0;
      if (w_drop) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (rx_valid) begin
            if ((rx_byte == CMD_WR) || (rx_byte == CMD_RD)) begin
              wr_q    <= (rx_byte == CMD_WR);
              cnt_q   <= 2'd0;
              state_q <= ST_ADDR;
            end else begin
              gw_byte_q  <= rx_byte;
              gw_valid_q <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (rx_valid) begin
            addr_q <= {addr_q[23:0], rx_byte};
            cnt_q  <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q <= wr_q ? ST_DATA : ST_BUS;
            end
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            wdata_q <= {wdata_q[23:0], rx_byte};
            cnt_q   <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          if (!bus_req_q) begin
            bus_req_q <= 1'b1;
          end else if (bus_ack) begin
            bus_req_q <= 1'b0;
            if (wr_q) begin
              state_q <= ST_IDLE;
            end else begin
              rdata_q    <= bus_rdata;
              tx_byte_q  <= CMD_RSP;
              tx_valid_q <= 1'b1;
              state_q    <= ST_RSP_HDR;
            end
          end
        end
        ST_RSP_HDR: begin
          if (w_tx_acc) begin
            tx_byte_q <= rdata_q[31:24];
            rdata_q   <= {rdata_q[23:0], 8'h00};
            cnt_q     <= 2'd0;
            state_q   <= ST_RSP_DATA;
          end
        end
        ST_RSP_DATA: begin
          if (w_tx_acc) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              tx_valid_q <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              tx_byte_q <= rdata_q[31:24];
              rdata_q   <= {rdata_q[23:0], 8'h00};
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
`ifdef SU_CMD_TIMEOUT_EN
      // Stalled host: abandon the partial command once the line is silent too long.
      if (((state_q == ST_ADDR) || (state_q == ST_DATA)) && !rx_valid) begin
        if (tmo_q == TIMEOUT_CYC) begin
          state_q <= ST_IDLE;
          cnt_q   <= 2'd0;
          tmo_q   <= 32'h0;
        end else begin
          tmo_q <= tmo_q + 32'd1;
        end
      end else begin
        tmo_q <= 32'h0;
      end
`endif
    end
  end

  assign tx_byte      = tx_byte_q;
  assign tx_valid     = tx_valid_q;
  assign gw_byte      = gw_byte_q;
  assign gw_valid     = gw_valid_q;
  assign bus_req      = bus_req_q;
  assign bus_wr       = wr_q;
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign busy         = (state_q != ST_IDLE);
  assign err_overflow = err_q;

endmodule

`default_nettype wire

// File: tb/tb_su_cmd_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_su_cmd_decoder                                                        |
// | Self-checking bench for su_cmd_decoder with a transaction-level model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_su_cmd_decoder;

  localparam logic [7:0] CMD_WR  = 8'hA1;
  localparam logic [7:0] CMD_RD  = 8'hA2;
  localparam logic [7:0] CMD_RSP = 8'hA3;
  localparam int unsigned TMO    = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  gw_byte;
  logic        gw_valid;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        busy;
  logic        err_overflow;

  su_cmd_decoder #(
    .CMD_WR(CMD_WR), .CMD_RD(CMD_RD), .CMD_RSP(CMD_RSP), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .gw_byte(gw_byte), .gw_valid(gw_valid),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .busy(busy), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int total = 0;
  int bad   = 0;

  txn_t       act_bus[$];
  txn_t       exp_bus[$];
  logic [7:0] act_gw[$];
  logic [7:0] exp_gw[$];
  logic [7:0] act_tx[$];
  logic [7:0] exp_tx[$];
  int         bus_unstable = 0;
  int         tx_unstable  = 0;

  int          ack_delay = 2;
  int          tx_mode   = 0;
  int          gap_max   = 0;
  logic [31:0] rsp_rdata = 32'h0;
  logic        tgl       = 1'b0;

  // Observers sample mid-low-phase, after the negedge drivers have settled.
  txn_t       cur = '0;
  logic       prev_req = 1'b0, prev_tv = 1'b0, prev_tr = 1'b0;
  logic [7:0] prev_tb = 8'h00;
  initial begin
    forever begin
      @(negedge clk); #2;
      if (bus_req && !prev_req) begin
        cur = {bus_wr, bus_addr, bus_wdata};
        act_bus.push_back(cur);
      end else if (bus_req && (cur !== {bus_wr, bus_addr, bus_wdata})) begin
        bus_unstable++;
      end
      if (gw_valid) act_gw.push_back(gw_byte);
      if (prev_tv && !prev_tr && (!tx_valid || tx_byte !== prev_tb)) tx_unstable++;
      if (tx_valid && tx_ready) act_tx.push_back(tx_byte);
      prev_req = bus_req; prev_tv = tx_valid; prev_tr = tx_ready; prev_tb = tx_byte;
    end
  end

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (tx_mode)
        0: tx_ready = 1'b1;
        1: begin tgl = ~tgl; tx_ready = tgl; end
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    bus_ack = 1'b0; bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus_req && !bus_ack) begin
        repeat (ack_delay) @(negedge clk);
        bus_ack = 1'b1; bus_rdata = rsp_rdata;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = $urandom;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_put(input logic [7:0] b);
    rx_byte = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
  endtask

  task automatic put_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) rx_put(w[i*8 +: 8]);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic clear_logs();
    act_bus.delete(); exp_bus.delete(); act_gw.delete(); exp_gw.delete();
    act_tx.delete(); exp_tx.delete();
    bus_unstable = 0; tx_unstable = 0;
  endtask

  task automatic push_rsp(input logic [31:0] rd);
    exp_tx.push_back(CMD_RSP);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[i*8 +: 8]);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b1; rx_byte = 8'h41;
    idle(3);
    total++;
    if ({tx_byte, tx_valid, gw_byte, gw_valid} !== 18'h0) begin
      bad++; $display("FAIL reset_tx_gw: got %0h want 0", {tx_byte, tx_valid, gw_byte, gw_valid});
    end
    total++;
    if ({bus_req, bus_wr, bus_addr, bus_wdata} !== 66'h0) begin
      bad++; $display("FAIL reset_bus: got %0h want 0", {bus_req, bus_wr, bus_addr, bus_wdata});
    end
    total++;
    if ({busy, err_overflow} !== 2'b00) begin
      bad++; $display("FAIL reset_flags: got %b want 00", {busy, err_overflow});
    end
    rst = 1'b0; rx_valid = 1'b0;
    idle(2);
  endtask

  task automatic test_write();
    bit ok;
    clear_logs(); ack_delay = 2; tx_mode = 0;
    rx_put(CMD_WR); put_word(32'h0000_1004); put_word(32'hDEAD_BEEF);
    wait_idle(ok); idle(2);
    total++;
    if (!ok) begin bad++; $display("FAIL write_done: busy still %b want 0", busy); end
    total++;
    if (act_bus.size() != 1 || act_bus[0] !== txn_t'{1'b1, 32'h0000_1004, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL write_txn: got n=%0d %0h want n=1 %0h", act_bus.size(),
                      act_bus.size() > 0 ? act_bus[0] : '0, txn_t'{1'b1, 32'h1004, 32'hDEADBEEF});
    end
    total++;
    if (bus_unstable != 0 || bus_req !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL write_hold: unstable=%0d req=%b busy=%b want 0 0 0", bus_unstable, bus_req, busy);
    end
  endtask

  task automatic test_read();
    bit ok;
    clear_logs(); ack_delay = 1; tx_mode = 1; rsp_rdata = 32'h1234_5678;
    push_rsp(32'h1234_5678);
    rx_put(CMD_RD); put_word(32'h0000_2000);
    wait_idle(ok); idle(2);
    total++;
    if (!ok) begin bad++; $display("FAIL read_done: busy still %b want 0", busy); end
    total++;
    if (act_bus.size() != 1 || act_bus[0].wr !== 1'b0 || act_bus[0].addr !== 32'h2000) begin
      bad++; $display("FAIL read_txn: got n=%0d addr=%0h want n=1 addr=2000", act_bus.size(),
                      act_bus.size() > 0 ? act_bus[0].addr : 32'h0);
    end
    total++;
    if (act_tx != exp_tx) begin
      bad++; $display("FAIL read_tx: got %p want %p", act_tx, exp_tx);
    end
    total++;
    if (tx_unstable != 0 || tx_valid !== 1'b0) begin
      bad++; $display("FAIL read_hold: unstable=%0d tx_valid=%b want 0 0", tx_unstable, tx_valid);
    end
  endtask

  task automatic test_gateway();
    clear_logs(); tx_mode = 0;
    rx_put(8'h41); rx_put(8'h0A);
    idle(3);
    exp_gw.push_back(8'h41); exp_gw.push_back(8'h0A);
    total++;
    if (act_gw != exp_gw) begin bad++; $display("FAIL gateway: got %p want %p", act_gw, exp_gw); end
    total++;
    if (act_bus.size() != 0) begin bad++; $display("FAIL gateway_bus: got %0d reqs want 0", act_bus.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs(); ack_delay = 0; tx_mode = 0; rsp_rdata = 32'hCAFE_F00D;
    rx_put(CMD_WR); put_word(32'h0000_0010); put_word(32'h0BAD_F00D);
    wait_idle(ok);
    rx_put(8'h5A);
    rx_put(CMD_RD); put_word(32'h0000_0020);
    wait_idle(ok);
    rx_put(8'h33);
    idle(3);
    exp_gw.push_back(8'h5A); exp_gw.push_back(8'h33);
    total++;
    if (act_gw != exp_gw) begin bad++; $display("FAIL b2b_gw: got %p want %p", act_gw, exp_gw); end
    total++;
    if (act_bus.size() != 2 || act_bus[1].addr !== 32'h20 || act_bus[0].wdata !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL b2b_bus: got n=%0d want 2 txns", act_bus.size());
    end
    total++;
    if (err_overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf: got %b want 0", err_overflow); end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_logs(); ack_delay = 6; tx_mode = 0;
    rx_put(CMD_WR); put_word(32'hAABB_CCDD); put_word(32'h1122_3344);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_req) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL ovf_req: bus_req got 0 want 1"); end
    rx_put(8'h55);
    wait_idle(ok); idle(2);
    total++;
    if (err_overflow !== 1'b1 || act_gw.size() != 0) begin
      bad++; $display("FAIL ovf_flag: err=%b gw=%0d want 1 0", err_overflow, act_gw.size());
    end
    total++;
    if (act_bus.size() != 1 || act_bus[0] !== txn_t'{1'b1, 32'hAABB_CCDD, 32'h1122_3344} || bus_unstable != 0) begin
      bad++; $display("FAIL ovf_txn: got n=%0d unstable=%0d want 1 0", act_bus.size(), bus_unstable);
    end
    rx_put(8'h41); idle(2);
    total++;
    if (err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", err_overflow); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs(); ack_delay = 2; tx_mode = 0; rsp_rdata = 32'h0F0E_0D0C;
    rx_put(CMD_WR); rx_put(8'h00); rx_put(8'h11);
    rst = 1'b1; idle(1); rst = 1'b0;
    total++;
    if ({bus_req, tx_valid, gw_valid, busy, err_overflow} !== 5'b0) begin
      bad++; $display("FAIL rstmid_out: got %b want 00000", {bus_req, tx_valid, gw_valid, busy, err_overflow});
    end
    push_rsp(32'h0F0E_0D0C);
    rx_put(CMD_RD); put_word(32'h0000_3000);
    wait_idle(ok); idle(2);
    total++;
    if (!ok || act_bus.size() != 1 || act_bus[0].wr !== 1'b0 || act_bus[0].addr !== 32'h3000) begin
      bad++; $display("FAIL rstmid_txn: got n=%0d addr=%0h want 1 3000", act_bus.size(),
                      act_bus.size() > 0 ? act_bus[0].addr : 32'h0);
    end
    total++;
    if (act_tx != exp_tx) begin bad++; $display("FAIL rstmid_tx: got %p want %p", act_tx, exp_tx); end
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] a, d;
    logic [7:0]  b;
    clear_logs(); tx_mode = 2; gap_max = 2;
    for (int n = 0; n < 40; n++) begin
      ack_delay = $urandom_range(0, 3);
      a = $urandom; d = $urandom;
      case ($urandom_range(0, 2))
        0: begin
          exp_bus.push_back(txn_t'{1'b1, a, d});
          rx_put(CMD_WR); put_word(a); put_word(d);
        end
        1: begin
          rsp_rdata = d;
          exp_bus.push_back(txn_t'{1'b0, a, 32'h0});
          push_rsp(d);
          rx_put(CMD_RD); put_word(a);
        end
        default: begin
          do b = 8'($urandom); while (b == CMD_WR || b == CMD_RD);
          exp_gw.push_back(b);
          rx_put(b);
        end
      endcase
      wait_idle(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rand_done: op %0d still busy", n); end
    end
    idle(3); gap_max = 0;
    total++;
    if (act_bus.size() != exp_bus.size()) begin
      bad++; $display("FAIL rand_bus_n: got %0d want %0d", act_bus.size(), exp_bus.size());
    end else begin
      for (int i = 0; i < exp_bus.size(); i++) begin
        total++;
        if (act_bus[i].wr !== exp_bus[i].wr || act_bus[i].addr !== exp_bus[i].addr ||
            (exp_bus[i].wr && act_bus[i].wdata !== exp_bus[i].wdata)) begin
          bad++; $display("FAIL rand_bus[%0d]: got %0h want %0h", i, act_bus[i], exp_bus[i]);
        end
      end
    end
    total++;
    if (act_tx != exp_tx) begin bad++; $display("FAIL rand_tx: got %p want %p", act_tx, exp_tx); end
    total++;
    if (act_gw != exp_gw) begin bad++; $display("FAIL rand_gw: got %p want %p", act_gw, exp_gw); end
    total++;
    if (bus_unstable != 0 || tx_unstable != 0 || err_overflow !== 1'b0) begin
      bad++; $display("FAIL rand_hold: bus=%0d tx=%0d err=%b want 0 0 0", bus_unstable, tx_unstable, err_overflow);
    end
  endtask

`ifdef SU_CMD_TIMEOUT_EN
  task automatic test_timeout();
    clear_logs(); tx_mode = 0;
    rx_put(CMD_RD); rx_put(8'h00); rx_put(8'h00);
    idle(60);
    total++;
    if (busy !== 1'b0 || act_bus.size() != 0) begin
      bad++; $display("FAIL timeout_idle: busy=%b reqs=%0d want 0 0", busy, act_bus.size());
    end
    rx_put(8'h41); idle(3);
    total++;
    if (act_gw.size() != 1 || act_gw[0] !== 8'h41) begin
      bad++; $display("FAIL timeout_gw: got %p want 41", act_gw);
    end
  endtask
`endif

  initial begin
    rx_byte = 8'h00; rx_valid = 1'b0; rst = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_gateway();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
`ifdef SU_CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/su_cmd_decoder.md
Name: su_cmd_decoder

Overview:
- Sits in the smart UART, between the UART byte receiver/transmitter and the on-chip word bus.
- Parses the host byte stream:
  - SU_CMD_WR_WORD + 4 address bytes + 4 data bytes issues a bus write.
  - SU_CMD_RD_WORD + 4 address bytes issues a bus read and returns SU_CMD_RSP + 4 data bytes.
- Any other byte received in IDLE is forwarded to the core gateway port as a plain terminal character.

Parameters:
- CMD_WR, `SU_CMD_WR_WORD, opcode byte for word write.
- CMD_RD, `SU_CMD_RD_WORD, opcode byte for word read.
- CMD_RSP, `SU_CMD_RSP, header byte prefixed to a read response.
- TIMEOUT_CYC, 1000000, inter-byte timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- rx_byte  in  8  received byte from UART RX.
- rx_valid  in  1  one-cycle strobe; no backpressure.
- tx_byte  out  8  byte to UART TX.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  UART TX accepts the byte when tx_valid&tx_ready.
- gw_byte  out  8  non-command byte to the core gateway.
- gw_valid  out  1  one-cycle strobe.
- bus_req  out  1  bus request.
- bus_wr  out  1  1 = write, 0 = read.
- bus_addr  out  32  word address.
- bus_wdata  out  32  write data.
- bus_ack  in  1  bus completion, sampled only while bus_req = 1.
- bus_rdata  in  32  read data, valid with bus_ack.
- busy  out  1  state != IDLE.
- err_overflow  out  1  sticky; set when a byte is dropped.

Behaviour:
- Reset values: all outputs 0 (tx_byte, gw_byte, bus_addr, bus_wdata included); state IDLE; byte counter 0.
- States: IDLE, ADDR, DATA, BUS, RSP_HDR, RSP_DATA. A 2-bit counter cnt indexes bytes, MSB first.
- IDLE, on rx_valid:
  - byte == CMD_WR: latch wr=1, go to ADDR, cnt=0.
  - byte == CMD_RD: latch wr=0, go to ADDR, cnt=0.
  - Otherwise: gw_byte=rx_byte and gw_valid=1 for exactly the next cycle (1-cycle latency).
- ADDR: each rx_valid shifts bus_addr left 8 and inserts the byte. After the 4th byte:
  - wr=1: go to DATA.
  - wr=0: go to BUS.
- DATA: same shifting into bus_wdata. After the 4th byte go to BUS.
- BUS:
  - bus_req=1 from the cycle after BUS is entered.
  - bus_wr, bus_addr and bus_wdata are stable while bus_req=1.
  - On bus_ack, bus_req=0 in the next cycle.
  - Write: return to IDLE.
  - Read: latch bus_rdata, go to RSP_HDR.
  - No bus timeout.
- RSP_HDR: tx_valid=1, tx_byte=CMD_RSP. On tx_ready go to RSP_DATA, cnt=0.
- RSP_DATA: tx_byte = rdata[31:24], [23:16], [15:8], [7:0] in order.
  - tx_valid stays high and tx_byte stays stable until accepted.
  - After the 4th accept: tx_valid=0, go to IDLE.
- rx_valid in BUS, RSP_HDR or RSP_DATA: byte is dropped and err_overflow is set. err_overflow is cleared only by rst.
- Simultaneous events:
  - rx_valid in the same cycle as bus_ack or the final tx accept: the byte is dropped (state is not yet IDLE) and err_overflow is set.
  - The first byte accepted is the one arriving on the first cycle in IDLE.
- Opcode bytes arriving in ADDR or DATA are treated as data, not re-parsed.
- Reset mid-operation: the next state is IDLE. bus_req, tx_valid and gw_valid are 0 the cycle after rst is sampled, and the partial command is discarded.

Optional Feature:
- SU_CMD_TIMEOUT_EN defined:
  - A counter clears on every rx_valid and increments in ADDR and DATA.
  - When it reaches TIMEOUT_CYC, state returns to IDLE, the partial command is discarded and no bus cycle occurs.
  - The counter is inactive in IDLE, BUS, RSP_HDR and RSP_DATA.
- Not defined: no counter logic. ADDR and DATA wait indefinitely.

Test Plan:
- Write: rx CMD_WR, 00 00 10 04, de ad be ef; ack 2 cycles later -> one bus_req pulse with bus_wr=1, addr=0x00001004, wdata=0xdeadbeef held until ack; busy=0 afterwards.
- Read: rx CMD_RD, 00 00 20 00; bus_rdata=0x12345678 with ack -> tx sequence CMD_RSP, 12, 34, 56, 78. With tx_ready toggling 1-0-1, each byte is held stable until accepted.
- Gateway: rx 0x41, 0x0A -> gw_valid pulses carrying 0x41 then 0x0A; bus_req stays 0.
- Overflow: rx byte 0x55 during BUS -> no gw_valid, err_overflow=1, and the current transaction completes normally.
- Reset mid-command: rx CMD_WR, 00 11, then rst for one cycle, then a full read command -> only the read is issued, with addr from the read bytes.
- Timeout (SU_CMD_TIMEOUT_EN, TIMEOUT_CYC=50): rx CMD_RD, 00, 00, then idle for 60 cycles -> state IDLE, no bus_req; the next byte 0x41 is forwarded on gw_byte.
